// File: rtl/l1i_tlb_assoc.sv
// Set-associative L1 instruction TLB with global pages, fill-time dedup and
// multi-cycle invalidate-all / invalidate-by-ASID sweeps.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | normal operation, lookups translate, fills accepted
// SWEEP_ALL  | clearing every way of set[cnt_q], one set per cycle
// SWEEP_ASID | clearing non-global ways of set[cnt_q] owned by iasid_q
module l1i_tlb_assoc #(
  parameter int NUM_SETS   = 16,
  parameter int NUM_WAYS   = 4,
  parameter int ASID_WIDTH = 8,
  parameter int PAGE_IDX_W = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  lookup_en,
  input  logic [PAGE_IDX_W-1:0] lookup_vpage,
  input  logic [ASID_WIDTH-1:0] lookup_asid,
  output logic                  lookup_valid,
  output logic                  lookup_hit,
  output logic [PAGE_IDX_W-1:0] lookup_ppage,
  input  logic                  update_en,
  input  logic [PAGE_IDX_W-1:0] update_vpage,
  input  logic [PAGE_IDX_W-1:0] update_ppage,
  input  logic [ASID_WIDTH-1:0] update_asid,
  input  logic                  update_global,
  input  logic                  inval_all,
  input  logic                  inval_asid_en,
  input  logic [ASID_WIDTH-1:0] inval_asid,
  output logic                  busy
);

  localparam int SET_W = $clog2(NUM_SETS);
  localparam int TAG_W = PAGE_IDX_W - SET_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef logic [WAY_W-1:0] way_t;
  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP_ALL, ST_SWEEP_ASID} state_e;

  logic                  valid_q  [NUM_SETS][NUM_WAYS];
  logic                  global_q [NUM_SETS][NUM_WAYS];
  logic [ASID_WIDTH-1:0] asid_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]      tag_q    [NUM_SETS][NUM_WAYS];
  logic [PAGE_IDX_W-1:0] ppage_q  [NUM_SETS][NUM_WAYS];
  way_t                  rr_q     [NUM_SETS];

  state_e                state_q, state_d;
  logic [SET_W-1:0]      cnt_q, cnt_d;
  logic [ASID_WIDTH-1:0] iasid_q, iasid_d;
  logic                  sweep_en;
  logic [NUM_WAYS-1:0]   sweep_clr;

  logic                  lk_valid_q, lk_hit_q;
  logic [PAGE_IDX_W-1:0] lk_ppage_q;
  logic                  lk_hit_d;
  logic [PAGE_IDX_W-1:0] lk_ppage_d;

  logic [SET_W-1:0]      lk_set, up_set;
  logic [TAG_W-1:0]      lk_tag, up_tag;
  logic                  lk_match;
  logic [PAGE_IDX_W-1:0] lk_match_pp;
  logic                  up_match, up_free, fill_fire, rr_adv;
  way_t                  up_match_way, up_free_way, fill_way;

  assign busy   = (state_q != ST_IDLE);
  assign lk_set = lookup_vpage[SET_W-1:0];
  assign lk_tag = lookup_vpage[PAGE_IDX_W-1:SET_W];
  assign up_set = update_vpage[SET_W-1:0];
  assign up_tag = update_vpage[PAGE_IDX_W-1:SET_W];

  // Lowest matching way wins, so a result is always well defined.
  always_comb begin
    lk_match    = 1'b0;
    lk_match_pp = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!lk_match && valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag) &&
          (global_q[lk_set][w] || (asid_q[lk_set][w] == lookup_asid))) begin
        lk_match    = 1'b1;
        lk_match_pp = ppage_q[lk_set][w];
      end
    end
  end

  always_comb begin
    up_match     = 1'b0;
    up_match_way = '0;
    up_free      = 1'b0;
    up_free_way  = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!up_match && valid_q[up_set][w] && (tag_q[up_set][w] == up_tag) &&
          (global_q[up_set][w] || (asid_q[up_set][w] == update_asid))) begin
        up_match     = 1'b1;
        up_match_way = way_t'(w);
      end
      if (!up_free && !valid_q[up_set][w]) begin
        up_free     = 1'b1;
        up_free_way = way_t'(w);
      end
    end
  end

  always_comb begin
    fill_way = rr_q[up_set];
    rr_adv   = 1'b0;
    if (up_match) begin
      fill_way = up_match_way;
    end else if (up_free) begin
      fill_way = up_free_way;
    end else begin
      rr_adv = 1'b1;
    end
  end

  // A fill colliding with an invalidate start is dropped.
  assign fill_fire = update_en && (state_q == ST_IDLE) && !inval_all && !inval_asid_en;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iasid_d  = iasid_q;
    sweep_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (inval_all) begin
          state_d = ST_SWEEP_ALL;
          cnt_d   = '0;
        end else if (inval_asid_en) begin
          state_d = ST_SWEEP_ASID;
          cnt_d   = '0;
          iasid_d = inval_asid;
        end
      end
      ST_SWEEP_ALL, ST_SWEEP_ASID: begin
        sweep_en = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SET_W'(NUM_SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sweep_clr = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      sweep_clr[w] = (state_q == ST_SWEEP_ALL) ||
                     (!global_q[cnt_q][w] && (asid_q[cnt_q][w] == iasid_q));
    end
  end

  always_comb begin
    lk_hit_d   = lookup_en && !busy && lk_match;
    lk_ppage_d = lk_hit_d ? lk_match_pp : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      iasid_q    <= '0;
      lk_valid_q <= 1'b0;
      lk_hit_q   <= 1'b0;
      lk_ppage_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iasid_q    <= iasid_d;
      lk_valid_q <= lookup_en;
      lk_hit_q   <= lk_hit_d;
      lk_ppage_q <= lk_ppage_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (fill_fire) begin
        valid_q[up_set][fill_way] <= 1'b1;
        if (rr_adv) begin
          rr_q[up_set] <= (rr_q[up_set] == way_t'(NUM_WAYS - 1)) ? '0
                                                               : rr_q[up_set] + way_t'(1);
        end
      end
      if (sweep_en) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (sweep_clr[w]) begin
            valid_q[cnt_q][w] <= 1'b0;
          end
        end
      end
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (fill_fire) begin
      global_q[up_set][fill_way] <= update_global;
      asid_q[up_set][fill_way]   <= update_asid;
      tag_q[up_set][fill_way]    <= up_tag;
      ppage_q[up_set][fill_way]  <= update_ppage;
    end
  end

  assign lookup_valid = lk_valid_q;
  assign lookup_hit   = lk_hit_q;
  assign lookup_ppage = lk_ppage_q;

endmodule

// File: tb/tb_l1i_tlb_assoc.sv
// Bench for l1i_tlb_assoc: table-driven vectors, directed sweep/reset sequences,
// and random traffic checked against a per-set array model of the TLB.
module tb_l1i_tlb_assoc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lookup_en;
  logic [19:0] lookup_vpage;
  logic [7:0]  lookup_asid;
  logic        lookup_valid, lookup_hit;
  logic [19:0] lookup_ppage;
  logic        update_en;
  logic [19:0] update_vpage, update_ppage;
  logic [7:0]  update_asid;
  logic        update_global;
  logic        inval_all, inval_asid_en;
  logic [7:0]  inval_asid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  l1i_tlb_assoc #(.NUM_SETS(16), .NUM_WAYS(4), .ASID_WIDTH(8), .PAGE_IDX_W(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .lookup_en(lookup_en), .lookup_vpage(lookup_vpage), .lookup_asid(lookup_asid),
    .lookup_valid(lookup_valid), .lookup_hit(lookup_hit), .lookup_ppage(lookup_ppage),
    .update_en(update_en), .update_vpage(update_vpage), .update_ppage(update_ppage),
    .update_asid(update_asid), .update_global(update_global),
    .inval_all(inval_all), .inval_asid_en(inval_asid_en), .inval_asid(inval_asid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: per-set list of entries, replacement by spec rules.
  bit m_v [16][4];
  bit m_g [16][4];
  int m_as[16][4];
  int m_tag[16][4];
  int m_pp[16][4];
  int m_rr[16];
  int m_busy;

  function automatic void m_reset();
    for (int s = 0; s < 16; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < 4; w++) m_v[s][w] = 0;
    end
    m_busy = 0;
  endfunction

  function automatic int m_find(int s, int t, int a);
    for (int w = 0; w < 4; w++)
      if (m_v[s][w] && m_tag[s][w] == t && (m_g[s][w] || m_as[s][w] == a)) return w;
    return -1;
  endfunction

  function automatic void m_fill(int vp, int pp, int a, bit g);
    int s, t, w;
    s = vp % 16;
    t = vp / 16;
    w = m_find(s, t, a);
    if (w < 0) for (int k = 3; k >= 0; k--) if (!m_v[s][k]) w = k;
    if (w < 0) begin
      w = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % 4;
    end
    m_v[s][w] = 1; m_g[s][w] = g; m_as[s][w] = a; m_tag[s][w] = t; m_pp[s][w] = pp;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    lookup_en = 0; update_en = 0; update_global = 0;
    inval_all = 0; inval_asid_en = 0;
  endtask

  // Advance one clock: predict from inputs, update model, compare after the edge.
  task automatic step();
    bit ev, eh, bb;
    int ep, w;
    bb = (m_busy > 0);
    ev = lookup_en; eh = 0; ep = 0;
    if (lookup_en && !bb) begin
      w = m_find(int'(lookup_vpage) % 16, int'(lookup_vpage) / 16, int'(lookup_asid));
      if (w >= 0) begin
        eh = 1;
        ep = m_pp[int'(lookup_vpage) % 16][w];
      end
    end
    if (bb) m_busy--;
    else if (inval_all || inval_asid_en) begin
      m_busy = 16;
      for (int s = 0; s < 16; s++)
        for (int k = 0; k < 4; k++)
          if (inval_all || (!m_g[s][k] && m_as[s][k] == int'(inval_asid))) m_v[s][k] = 0;
    end else if (update_en)
      m_fill(int'(update_vpage), int'(update_ppage), int'(update_asid), update_global);
    @(posedge clk);
    #1;
    chk("m_valid", 32'(lookup_valid), 32'(ev));
    if (ev) begin
      chk("m_hit", 32'(lookup_hit), 32'(eh));
      chk("m_ppage", 32'(lookup_ppage), ep);
    end
    chk("m_busy", 32'(busy), 32'(m_busy > 0));
  endtask

  task automatic do_lookup(input logic [19:0] vp, input logic [7:0] a);
    idle(); lookup_en = 1; lookup_vpage = vp; lookup_asid = a; step(); idle();
  endtask

  task automatic do_fill(input logic [19:0] vp, input logic [19:0] pp, input logic [7:0] a,
                         input bit g);
    idle(); update_en = 1; update_vpage = vp; update_ppage = pp; update_asid = a;
    update_global = g; step(); idle();
  endtask

  typedef struct {
    bit          fill;
    bit          glob;
    logic [19:0] vp;
    logic [19:0] pp;
    logic [7:0]  asid;
    bit          hit;
    logic [19:0] exp_pp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    vecs.push_back('{0, 0, 20'h12345, 20'h0,     8'd3, 0, 20'h0});
    vecs.push_back('{1, 0, 20'h12345, 20'hABCDE, 8'd3, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h12345, 20'h0,     8'd3, 1, 20'hABCDE});
    vecs.push_back('{0, 0, 20'h12345, 20'h0,     8'd4, 0, 20'h0});
    vecs.push_back('{1, 1, 20'h12345, 20'hABCDE, 8'd3, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h12345, 20'h0,     8'd4, 1, 20'hABCDE});
    vecs.push_back('{0, 0, 20'h12345, 20'h0,     8'd3, 1, 20'hABCDE});
    for (int i = 1; i <= 5; i++)
      vecs.push_back('{1, 0, 20'((i << 4) | 6), 20'(32'h100 + i - 1), 8'd1, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h00016, 20'h0, 8'd1, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h00026, 20'h0, 8'd1, 1, 20'h101});
    vecs.push_back('{0, 0, 20'h00056, 20'h0, 8'd1, 1, 20'h104});
    vecs.push_back('{1, 0, 20'h00036, 20'h1AA, 8'd1, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h00036, 20'h0, 8'd1, 1, 20'h1AA});
    vecs.push_back('{0, 0, 20'h00036, 20'h0, 8'd2, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h00026, 20'h0, 8'd1, 1, 20'h101});
    vecs.push_back('{0, 0, 20'h00046, 20'h0, 8'd1, 1, 20'h103});
    vecs.push_back('{0, 0, 20'h00056, 20'h0, 8'd1, 1, 20'h104});
    vecs.push_back('{1, 0, 20'h00066, 20'h106, 8'd1, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h00026, 20'h0, 8'd1, 0, 20'h0});
    vecs.push_back('{0, 0, 20'h00066, 20'h0, 8'd1, 1, 20'h106});
    vecs.push_back('{0, 0, 20'h00036, 20'h0, 8'd1, 1, 20'h1AA});

    reset_n = 0;
    idle();
    lookup_vpage = 0; lookup_asid = 0; update_vpage = 0; update_ppage = 0;
    update_asid = 0; inval_asid = 0;
    m_reset();
    #1;
    chk("rst_valid", 32'(lookup_valid), 0);
    chk("rst_hit", 32'(lookup_hit), 0);
    chk("rst_ppage", 32'(lookup_ppage), 0);
    chk("rst_busy", 32'(busy), 0);
    #12 reset_n = 1;

    foreach (vecs[i]) begin
      if (vecs[i].fill) do_fill(vecs[i].vp, vecs[i].pp, vecs[i].asid, vecs[i].glob);
      else begin
        do_lookup(vecs[i].vp, vecs[i].asid);
        chk($sformatf("vec%0d_hit", i), 32'(lookup_hit), 32'(vecs[i].hit));
        chk($sformatf("vec%0d_ppage", i), 32'(lookup_ppage), 32'(vecs[i].exp_pp));
      end
    end

    // Invalidate-by-ASID keeps other ASIDs and globals.
    do_fill(20'h00A07, 20'h111, 8'd1, 0);
    do_fill(20'h00B07, 20'h222, 8'd2, 0);
    do_fill(20'h00C07, 20'h333, 8'd1, 1);
    idle(); inval_asid_en = 1; inval_asid = 8'd1; step(); idle();
    inval_asid = 8'd2;
    nb = busy ? 1 : 0;
    for (int i = 0; i < 40 && busy; i++) begin
      step();
      if (busy) nb++;
    end
    chk("asid_busy_len", nb, 16);
    do_lookup(20'h00A07, 8'd1); chk("asid_gone", 32'(lookup_hit), 0);
    do_lookup(20'h00B07, 8'd2); chk("asid2_kept", 32'(lookup_ppage), 32'h222);
    do_lookup(20'h00C07, 8'd1); chk("global_kept", 32'(lookup_ppage), 32'h333);

    // Invalidate-all with a colliding fill; traffic during the sweep.
    idle(); inval_all = 1;
    update_en = 1; update_vpage = 20'h00D08; update_ppage = 20'h444; update_asid = 8'd5;
    step(); idle();
    for (int i = 0; i < 5; i++) begin
      lookup_en = 1; lookup_vpage = 20'h00B07; lookup_asid = 8'd2;
      update_en = 1; update_vpage = 20'h00E09; update_ppage = 20'h666; update_asid = 8'd5;
      inval_asid_en = (i == 2);
      step(); idle();
      chk("busy_look_valid", 32'(lookup_valid), 1);
      chk("busy_look_hit", 32'(lookup_hit), 0);
    end
    for (int i = 0; i < 40 && busy; i++) step();
    chk("all_sweep_end", 32'(busy), 0);
    do_lookup(20'h00D08, 8'd5); chk("fill_at_start_dropped", 32'(lookup_hit), 0);
    do_lookup(20'h00E09, 8'd5); chk("fill_in_busy_dropped", 32'(lookup_hit), 0);
    do_lookup(20'h00B07, 8'd2); chk("all_cleared", 32'(lookup_hit), 0);
    do_lookup(20'h12345, 8'd4); chk("global_cleared", 32'(lookup_hit), 0);

    // Read-before-write on a same-cycle fill and lookup.
    idle();
    lookup_en = 1; lookup_vpage = 20'h00F0A; lookup_asid = 8'd7;
    update_en = 1; update_vpage = 20'h00F0A; update_ppage = 20'h555; update_asid = 8'd7;
    step(); idle();
    chk("rbw_miss", 32'(lookup_hit), 0);
    do_lookup(20'h00F0A, 8'd7); chk("rbw_next_hit", 32'(lookup_ppage), 32'h555);

    // Reset mid-sweep.
    idle(); inval_asid_en = 1; inval_asid = 8'd9; step(); idle();
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_busy", 32'(busy), 1);
    #2 reset_n = 0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(lookup_valid), 0);
    m_reset();
    #10 reset_n = 1;
    do_lookup(20'h00F0A, 8'd7); chk("midrst_entry_gone", 32'(lookup_hit), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      idle();
      lookup_en     = 1'($urandom_range(0, 1));
      lookup_vpage  = 20'(($urandom_range(0, 5) << 4) | $urandom_range(0, 3));
      lookup_asid   = 8'($urandom_range(0, 3));
      update_en     = ($urandom_range(0, 9) < 4);
      update_vpage  = 20'(($urandom_range(0, 5) << 4) | $urandom_range(0, 3));
      update_ppage  = 20'($urandom);
      update_asid   = 8'($urandom_range(0, 3));
      update_global = ($urandom_range(0, 4) == 0);
      inval_all     = ($urandom_range(0, 199) == 0);
      inval_asid_en = ($urandom_range(0, 149) == 0);
      inval_asid    = 8'($urandom_range(0, 3));
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
